cic_dec_ctrl: RTL and testbench
===============================

Name: cic_dec_ctrl

Overview:
Sequencer for the multistage CIC decimator (integrator, decimate, comb chain).
- Generates the integrator/comb clear and the decimation strobe at a programmable power-of-two ratio.
- Discards the comb pipeline's start-up transient.
- Rounds and saturates the wide comb result to the output width.
- Delivers the result through a valid/ready output register with sticky overrun detection.
- Sits between the decimator datapath and the downstream consumer, clocked by the divided CIC clock.

Parameters:
N_STAGE, 6, number of CIC stages; sets the start-up flush count and the per-octave gain shift.
LOG2M_W, 3, width of the ratio config; ratio M = 2^cfg_log2m, range 1..128.
DATA_W, 44, comb output width.
OUT_W, 24, output sample width (signed).

Ports:
clk  in  1  CIC datapath clock.
rst  in  1  asynchronous reset, active-low.
en  in  1  run enable; level-sensitive.
cfg_log2m  in  LOG2M_W  decimation ratio exponent; latched on IDLE->FLUSH.
int_clr  out  1  clear for integrators and comb delay lines.
dec_stb  out  1  one-cycle decimation strobe to the decimate/comb stages.
comb_vld  in  1  comb result valid (one cycle per strobe).
comb_dout  in  DATA_W  signed comb result.
dout  out  OUT_W  rounded, saturated output sample.
dout_vld  out  1  output valid.
dout_rdy  in  1  consumer ready.
ovf  out  1  sticky overrun flag.
ovf_clr  in  1  one-cycle overrun clear.
busy  out  1  high in FLUSH or RUN.

Behaviour:
Reset values (rst=0, asynchronous):
- State IDLE; int_clr=1; dec_stb=0; dout=0; dout_vld=0; ovf=0; busy=0.
- Counters 0; latched shift 0.

State machine: IDLE, FLUSH, RUN. All outputs are registered.
- IDLE:
  - int_clr=1, dec_stb=0.
  - On en=1: latch k=cfg_log2m and shift=N_STAGE*k, clear ratio counter and flush counter, go to FLUSH.
- FLUSH:
  - int_clr=0.
  - Each comb_vld is discarded and increments flush_cnt.
  - When flush_cnt reaches N_STAGE, go to RUN.
- RUN:
  - Each comb_vld is scaled and offered to the output register.
- en=0 in FLUSH or RUN: next cycle goes to IDLE, dout_vld is cleared, and any pending sample is dropped. This does not set ovf.
- cfg_log2m changes outside IDLE are ignored until the next start.

Ratio counter (FLUSH and RUN):
- cnt counts 0..M-1 and wraps.
- dec_stb=1 in the cycle after cnt==M-1, so the first strobe occurs M cycles after entering FLUSH, then every M cycles.
- M=1: dec_stb is held high continuously.

Scaling:
- Form ext = sign-extended comb_dout to DATA_W+1 bits.
- If shift>0, add 2^(shift-1) (round half up).
- Arithmetic right shift by shift.
- Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- shift=0 passes through with saturation only.

Output register:
- Accepted comb_vld in RUN loads dout the next cycle and sets dout_vld (latency 1).
- Hold rule: while dout_vld=1 and dout_rdy=0, dout stays stable.
- Transfer: dout_vld and dout_rdy both high clears dout_vld, unless a new sample loads in the same cycle, in which case dout_vld stays 1 with the new data.
- Overrun: comb_vld in RUN while dout_vld=1 and dout_rdy=0 drops the new sample, keeps the old one, and sets ovf.
- ovf clears on ovf_clr or on the IDLE->FLUSH transition. If set and clear occur in the same cycle, set wins.
- busy = (state != IDLE).

Decomposition:
- Shared package cic_pkg holds:
  - State encoding (IDLE/FLUSH/RUN).
  - Default N_STAGE, DATA_W, OUT_W.
  - Function computing shift from N_STAGE and k.
- One natural sub-module, cic_round_sat: combinational round, shift and saturate, parameterised by DATA_W/OUT_W.
- Counters, FSM and output register stay in the top module.

Test Plan:
- Startup/strobe, N_STAGE=6, k=2 (M=4), en rises at cycle 0:
  - int_clr falls at cycle 1.
  - dec_stb pulses at cycles 5, 9, 13, …
  - First 6 comb_vld are discarded (dout_vld stays 0); the 7th produces dout_vld.
- Rounding, shift=12:
  - comb_dout=0x1000 -> dout=1.
  - 0x0800 -> 1.
  - 0x07FF -> 0.
  - -0x0801 (sign-extended) -> -1.
- Saturation, shift=12:
  - comb_dout=2^40 -> dout=0x7FFFFF.
  - comb_dout=-2^40 -> dout=0x800000.
- Backpressure, RUN, dout_rdy held 0:
  - Second comb_vld leaves dout unchanged and sets ovf.
  - ovf_clr pulse -> ovf=0.
  - dout_rdy=1 coinciding with a new comb_vld -> new value, dout_vld stays 1, ovf stays 0.
- Abort mid-operation: en=0 in RUN with dout_vld=1 -> next cycle IDLE, int_clr=1, dout_vld=0, dec_stb=0, busy=0.
- Reset and M=1 corner:
  - rst low mid-RUN -> all outputs at reset values immediately (asynchronous).
  - Restart with k=0 -> dec_stb high every cycle; shift=0 passes values with saturation only.

Source files
------------

// File: rtl/cic_pkg.sv
// -----------------------------------------------------------------------------
// cic_pkg
// Shared definitions for the CIC decimator sequencer:
//   - FSM state encoding (IDLE / FLUSH / RUN)
//   - default stage count and data widths
//   - cic_shift(): gain-compensation shift for N stages at ratio 2^k
// -----------------------------------------------------------------------------
package cic_pkg;

   localparam int N_STAGE_DEF = 6;
   localparam int LOG2M_W_DEF = 3;
   localparam int DATA_W_DEF  = 44;
   localparam int OUT_W_DEF   = 24;

   // Wide enough for N_STAGE * (2^LOG2M_W - 1) with the defaults (6*7 = 42).
   localparam int SHIFT_W     = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FLUSH = 2'd1,
      RUN   = 2'd2
   } cic_state_e;

   // CIC gain is M^N = 2^(N*k), so compensation is a right shift by N*k.
   function automatic logic [SHIFT_W-1:0] cic_shift(input int n_stage, input int k);
      return SHIFT_W'(n_stage * k);
   endfunction

endpackage

// File: rtl/cic_round_sat.sv
// -----------------------------------------------------------------------------
// cic_round_sat
// Combinational round-half-up, arithmetic right shift and saturation of the
// signed comb result down to the signed output width.
// Ports:
//   i_din   [DATA_W-1:0]  signed comb result
//   i_shift [SHIFT_W-1:0] right-shift amount (0 = saturate only)
//   o_dout  [OUT_W-1:0]   rounded, saturated signed sample
// -----------------------------------------------------------------------------
module cic_round_sat
   import cic_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int OUT_W  = OUT_W_DEF
) (
   input  logic [DATA_W-1:0]  i_din,
   input  logic [SHIFT_W-1:0] i_shift,
   output logic [OUT_W-1:0]   o_dout
);

   // Two guard bits: one for the sign extension, one so the rounding add
   // can never wrap even for a shift close to DATA_W.
   localparam int EW = DATA_W + 2;

   localparam logic signed [EW-1:0] SAT_MAX = {{(EW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [EW-1:0] SAT_MIN = {{(EW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   logic signed [EW-1:0] w_ext;
   logic signed [EW-1:0] w_half;
   logic signed [EW-1:0] w_rnd;
   logic signed [EW-1:0] w_shf;

   always_comb begin
      w_ext  = {{2{i_din[DATA_W-1]}}, i_din};
      w_half = '0;
      if (i_shift != '0) begin
         w_half = EW'(1) << (i_shift - 1'b1);
      end
      w_rnd = w_ext + w_half;
      w_shf = w_rnd >>> i_shift;

      if (w_shf > SAT_MAX) begin
         o_dout = SAT_MAX[OUT_W-1:0];
      end else if (w_shf < SAT_MIN) begin
         o_dout = SAT_MIN[OUT_W-1:0];
      end else begin
         o_dout = w_shf[OUT_W-1:0];
      end
   end

endmodule

// File: rtl/cic_dec_ctrl.sv
// -----------------------------------------------------------------------------
// cic_dec_ctrl
// Sequencer for a multistage CIC decimator running on the divided CIC clock.
// Generates the integrator/comb clear and the decimation strobe at ratio
// M = 2^cfg_log2m, discards the first N_STAGE comb results (start-up
// transient), rounds/saturates the comb result and hands it to a downstream
// consumer through a valid/ready output register with sticky overrun flag.
//
// Handshake: a sample transfers on a rising clock edge where o_dout_vld and
// i_dout_rdy are both high. While o_dout_vld=1 and i_dout_rdy=0, o_dout is
// held stable; a comb result arriving then is dropped and sets o_ovf.
//
// Ports:
//   i_clk          CIC datapath clock
//   i_rst_n        asynchronous reset, active-low
//   i_en           run enable (level)
//   i_cfg_log2m    ratio exponent, latched on IDLE->FLUSH
//   o_int_clr      clear for integrators and comb delay lines
//   o_dec_stb      one-cycle decimation strobe (held high when M=1)
//   i_comb_vld     comb result valid
//   i_comb_dout    signed comb result
//   o_dout         rounded, saturated output sample
//   o_dout_vld     output valid
//   i_dout_rdy     consumer ready
//   o_ovf          sticky overrun flag
//   i_ovf_clr      one-cycle overrun clear
//   o_busy         high in FLUSH or RUN
//   o_state        current FSM state (debug)
// -----------------------------------------------------------------------------
module cic_dec_ctrl
   import cic_pkg::*;
#(
   parameter int N_STAGE = N_STAGE_DEF,
   parameter int LOG2M_W = LOG2M_W_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int OUT_W   = OUT_W_DEF
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_en,
   input  logic [LOG2M_W-1:0] i_cfg_log2m,
   output logic               o_int_clr,
   output logic               o_dec_stb,
   input  logic               i_comb_vld,
   input  logic [DATA_W-1:0]  i_comb_dout,
   output logic [OUT_W-1:0]   o_dout,
   output logic               o_dout_vld,
   input  logic               i_dout_rdy,
   output logic               o_ovf,
   input  logic               i_ovf_clr,
   output logic               o_busy,
   output cic_state_e         o_state
);

   // Ratio counter must hold up to M-1 = 2^(2^LOG2M_W - 1) - 1.
   localparam int CNT_W = (1 << LOG2M_W) - 1;
   localparam int FL_W  = $clog2(N_STAGE + 1);

   cic_state_e         r_state;
   cic_state_e         w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic [CNT_W-1:0]   w_mmask;
   logic [FL_W-1:0]    r_flush_cnt;
   logic [FL_W-1:0]    w_flush_nxt;
   logic               w_start;
   logic [LOG2M_W-1:0] r_k;
   logic [SHIFT_W-1:0] r_shift;

   logic               r_int_clr;
   logic               r_dec_stb;
   logic               r_busy;
   logic [OUT_W-1:0]   r_dout;
   logic               r_dout_vld;
   logic               r_ovf;

   logic               w_accept;
   logic               w_ovr;
   logic               w_load;
   logic [OUT_W-1:0]   w_scaled;

   // M-1 for the latched ratio.
   assign w_mmask = CNT_W'(({{CNT_W{1'b0}}, 1'b1} << r_k) - 1'b1);

   cic_round_sat #(
      .DATA_W (DATA_W),
      .OUT_W  (OUT_W)
   ) u_round_sat (
      .i_din   (i_comb_dout),
      .i_shift (r_shift),
      .o_dout  (w_scaled)
   );

   // Next state, ratio counter and flush counter.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_flush_nxt = r_flush_cnt;
      w_start     = 1'b0;
      case (r_state)
         IDLE: begin
            if (i_en) begin
               w_state_nxt = FLUSH;
               w_start     = 1'b1;
               w_cnt_nxt   = '0;
               w_flush_nxt = '0;
            end
         end
         FLUSH: begin
            if (!i_en) begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
               w_flush_nxt = '0;
            end else begin
               w_cnt_nxt = (r_cnt == w_mmask) ? '0 : r_cnt + 1'b1;
               if (i_comb_vld) begin
                  w_flush_nxt = r_flush_cnt + 1'b1;
                  if (w_flush_nxt == FL_W'(N_STAGE)) begin
                     w_state_nxt = RUN;
                  end
               end
            end
         end
         RUN: begin
            if (!i_en) begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
               w_flush_nxt = '0;
            end else begin
               w_cnt_nxt = (r_cnt == w_mmask) ? '0 : r_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_flush_nxt = '0;
         end
      endcase
   end

   // Output register control: a sample arriving while the held one is
   // blocked is an overrun; otherwise it loads (possibly replacing a sample
   // that transfers on the same edge).
   always_comb begin
      w_accept = (r_state == RUN) && i_en && i_comb_vld;
      w_ovr    = w_accept && r_dout_vld && !i_dout_rdy;
      w_load   = w_accept && !w_ovr;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_flush_cnt <= '0;
         r_k         <= '0;
         r_shift     <= '0;
         r_int_clr   <= 1'b1;
         r_dec_stb   <= 1'b0;
         r_busy      <= 1'b0;
         r_dout      <= '0;
         r_dout_vld  <= 1'b0;
         r_ovf       <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_flush_cnt <= w_flush_nxt;
         if (w_start) begin
            r_k     <= i_cfg_log2m;
            r_shift <= cic_shift(N_STAGE, int'(i_cfg_log2m));
         end
         r_int_clr <= (w_state_nxt == IDLE);
         r_busy    <= (w_state_nxt != IDLE);
         // Strobe follows the cycle where the counter sits at M-1; for M=1
         // that is every cycle, so the strobe stays high.
         r_dec_stb <= (r_state != IDLE) && i_en && (r_cnt == w_mmask);

         if ((r_state != IDLE) && !i_en) begin
            r_dout_vld <= 1'b0;
         end else if (w_load) begin
            r_dout     <= w_scaled;
            r_dout_vld <= 1'b1;
         end else if (r_dout_vld && i_dout_rdy) begin
            r_dout_vld <= 1'b0;
         end

         // Set has priority over either clear source.
         if (w_ovr) begin
            r_ovf <= 1'b1;
         end else if (i_ovf_clr || w_start) begin
            r_ovf <= 1'b0;
         end
      end
   end

   assign o_state    = r_state;
   assign o_int_clr  = r_int_clr;
   assign o_dec_stb  = r_dec_stb;
   assign o_busy     = r_busy;
   assign o_dout     = r_dout;
   assign o_dout_vld = r_dout_vld;
   assign o_ovf      = r_ovf;

endmodule

// File: tb/tb_cic_dec_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cic_dec_ctrl
// Directed bench for cic_dec_ctrl. Expected output samples are queued when a
// comb result is issued; a monitor pops and compares on every transfer.
// Control/status outputs are compared directly against hand-derived values.
// -----------------------------------------------------------------------------
module tb_cic_dec_ctrl;
   import cic_pkg::*;

   localparam int N_STAGE = 6;
   localparam int LOG2M_W = 3;
   localparam int DATA_W  = 44;
   localparam int OUT_W   = 24;

   // ---------------- clock / reset ----------------
   logic clk;
   logic rst_n;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic               en;
   logic [LOG2M_W-1:0] cfg_log2m;
   logic               int_clr;
   logic               dec_stb;
   logic               comb_vld;
   logic [DATA_W-1:0]  comb_dout;
   logic [OUT_W-1:0]   dout;
   logic               dout_vld;
   logic               dout_rdy;
   logic               ovf;
   logic               ovf_clr;
   logic               busy;
   cic_state_e         state;

   cic_dec_ctrl #(
      .N_STAGE (N_STAGE),
      .LOG2M_W (LOG2M_W),
      .DATA_W  (DATA_W),
      .OUT_W   (OUT_W)
   ) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_en        (en),
      .i_cfg_log2m (cfg_log2m),
      .o_int_clr   (int_clr),
      .o_dec_stb   (dec_stb),
      .i_comb_vld  (comb_vld),
      .i_comb_dout (comb_dout),
      .o_dout      (dout),
      .o_dout_vld  (dout_vld),
      .i_dout_rdy  (dout_rdy),
      .o_ovf       (ovf),
      .i_ovf_clr   (ovf_clr),
      .o_busy      (busy),
      .o_state     (state)
   );

   // ---------------- scoreboard ----------------
   logic [OUT_W-1:0] exp_q[$];
   logic [OUT_W-1:0] mon_exp;
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Transfer monitor: vld&rdy seen mid-cycle means a transfer on the next edge.
   always @(negedge clk) begin
      if (rst_n && dout_vld && dout_rdy) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL dout_unexpected got %0h expected none at %0t", dout, $time);
         end else begin
            mon_exp = exp_q.pop_front();
            if (dout !== mon_exp) begin
               n_errors++;
               $display("FAIL dout_xfer got %0h expected %0h at %0t", dout, mon_exp, $time);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [DATA_W-1:0] d, input logic push, input logic [OUT_W-1:0] e);
      comb_vld  = 1'b1;
      comb_dout = d;
      if (push) exp_q.push_back(e);
      tick();
      comb_vld  = 1'b0;
   endtask

   task automatic flush_n(input int n);
      for (int i = 0; i < n; i++) begin
         comb_vld  = 1'b1;
         comb_dout = 44'h123;
         tick();
         comb_vld  = 1'b0;
         check("flush_dout_vld", 64'(dout_vld), 64'd0);
      end
      check("flush_to_run", 64'(state), 64'(RUN));
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_int_clr"},  64'(int_clr),  64'd1);
      check({tag, "_dec_stb"},  64'(dec_stb),  64'd0);
      check({tag, "_dout"},     64'(dout),     64'd0);
      check({tag, "_dout_vld"}, 64'(dout_vld), 64'd0);
      check({tag, "_ovf"},      64'(ovf),      64'd0);
      check({tag, "_busy"},     64'(busy),     64'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_n     = 1'b0;
      en        = 1'b0;
      cfg_log2m = '0;
      comb_vld  = 1'b0;
      comb_dout = '0;
      dout_rdy  = 1'b1;
      ovf_clr   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_vals("rst");
      rst_n = 1'b1;
      tick();

      // Startup and strobe timing, k=2 (M=4, shift=12); en rises in cycle 0.
      cfg_log2m = 3'd2;
      en        = 1'b1;
      tick();                      // cycle 1
      cfg_log2m = 3'd5;            // must be ignored until next start
      check("start_int_clr", 64'(int_clr), 64'd0);
      check("start_busy",    64'(busy),    64'd1);
      for (int c = 1; c <= 13; c++) begin
         check("stb_m4", 64'(dec_stb), 64'((c == 5) || (c == 9) || (c == 13)));
         tick();
      end

      // Six comb results are discarded, the seventh is delivered.
      flush_n(N_STAGE);

      // Rounding and saturation, shift=12, consumer always ready.
      send(44'h000_0000_1000, 1'b1, 24'h000001);
      check("first_dout_vld", 64'(dout_vld), 64'd1);
      send(44'h000_0000_0800, 1'b1, 24'h000001);
      send(44'h000_0000_07FF, 1'b1, 24'h000000);
      send(44'hFFF_FFFF_F7FF, 1'b1, 24'hFFFFFF);
      send(44'h100_0000_0000, 1'b1, 24'h7FFFFF);
      send(44'hF00_0000_0000, 1'b1, 24'h800000);
      tick();
      check("drain_dout_vld", 64'(dout_vld), 64'd0);

      // Backpressure and overrun.
      dout_rdy = 1'b0;
      send(44'h000_0000_3000, 1'b1, 24'h000003);
      check("bp_dout",     64'(dout),     64'h3);
      check("bp_dout_vld", 64'(dout_vld), 64'd1);
      send(44'h000_0000_5000, 1'b0, 24'h0);
      check("ovr_dout_hold", 64'(dout),     64'h3);
      check("ovr_ovf",       64'(ovf),      64'd1);
      check("ovr_dout_vld",  64'(dout_vld), 64'd1);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      check("ovf_clr", 64'(ovf), 64'd0);
      ovf_clr = 1'b1;              // set and clear together: set wins
      send(44'h000_0000_6000, 1'b0, 24'h0);
      ovf_clr = 1'b0;
      check("ovf_set_wins", 64'(ovf),  64'd1);
      check("ovr2_dout",    64'(dout), 64'h3);
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      check("ovf_clr2", 64'(ovf), 64'd0);
      dout_rdy = 1'b1;             // transfer coincides with a new sample
      send(44'h000_0000_7000, 1'b1, 24'h000007);
      check("xfer_load_dout",     64'(dout),     64'h7);
      check("xfer_load_dout_vld", 64'(dout_vld), 64'd1);
      check("xfer_load_ovf",      64'(ovf),      64'd0);
      tick();
      check("xfer_done_vld", 64'(dout_vld), 64'd0);

      // Abort in RUN with a pending sample.
      dout_rdy = 1'b0;
      send(44'h000_0000_2000, 1'b0, 24'h0);
      check("abort_pre_vld", 64'(dout_vld), 64'd1);
      en = 1'b0;
      tick();
      check("abort_state",    64'(state),    64'(IDLE));
      check("abort_int_clr",  64'(int_clr),  64'd1);
      check("abort_dout_vld", 64'(dout_vld), 64'd0);
      check("abort_dec_stb",  64'(dec_stb),  64'd0);
      check("abort_busy",     64'(busy),     64'd0);
      check("abort_ovf",      64'(ovf),      64'd0);

      // Asynchronous reset in RUN with overrun pending.
      cfg_log2m = 3'd2;
      en        = 1'b1;
      tick();
      flush_n(N_STAGE);
      send(44'h000_0000_1000, 1'b0, 24'h0);
      send(44'h000_0000_2000, 1'b0, 24'h0);
      check("pre_rst_ovf", 64'(ovf), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_vals("async_rst");
      en = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // M=1: strobe held high, shift=0 saturates only.
      dout_rdy  = 1'b1;
      cfg_log2m = 3'd0;
      en        = 1'b1;
      tick();                      // cycle 1
      check("m1_stb_c1", 64'(dec_stb), 64'd0);
      tick();
      for (int i = 0; i < 3; i++) begin
         check("m1_stb", 64'(dec_stb), 64'd1);
         tick();
      end
      flush_n(N_STAGE);
      send(44'h000_0012_3456, 1'b1, 24'h123456);
      send(44'h000_007F_FFFF, 1'b1, 24'h7FFFFF);
      send(44'h000_0080_0000, 1'b1, 24'h7FFFFF);
      send(44'hFFF_FF80_0000, 1'b1, 24'h800000);
      send(44'hFFF_FF7F_FFFF, 1'b1, 24'h800000);
      send(44'hFFF_FFFF_FFFB, 1'b1, 24'hFFFFFB);
      check("m1_stb_run", 64'(dec_stb), 64'd1);
      tick();
      tick();
      check("queue_empty", 64'(exp_q.size()), 64'd0);
      en = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
